// File: rtl/serial_magnitude_comparator_pkg.sv
// rtl/serial_magnitude_comparator_pkg.sv - shared state encoding and sizing helpers for the serial comparator
package serial_magnitude_comparator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit compare still needs one counter bit to keep the logic uniform.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

  function automatic bit digits_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// rtl/serial_magnitude_comparator_if.sv - compare request/result bundle between control logic and comparator
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  import serial_magnitude_comparator_pkg::*;

  logic             en;
  logic             start;
  logic             signed_cmp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             greater;
  logic             equal;
  logic             less;

  modport master (
    output en, start, signed_cmp, a, b,
    input  busy, done, greater, equal, less
  );

  modport slave (
    input  en, start, signed_cmp, a, b,
    output busy, done, greater, equal, less
  );

endinterface

// File: rtl/serial_magnitude_comparator_digit_compare.sv
// rtl/serial_magnitude_comparator_digit_compare.sv - combinational DIGIT-bit magnitude compare
module digit_compare
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_gt,
  output logic             o_eq
);

  // MSB-first ripple: a lower bit only counts while every higher bit matched.
  always_comb begin
    logic w_prefix_eq;
    logic w_gt;
    w_prefix_eq = 1'b1;
    w_gt        = 1'b0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      w_gt        = w_gt | (w_prefix_eq & i_a[i] & ~i_b[i]);
      w_prefix_eq = w_prefix_eq & ~(i_a[i] ^ i_b[i]);
    end
    o_gt = w_gt;
    o_eq = w_prefix_eq;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - multi-cycle MSB-first magnitude comparator with early exit
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                          i_clk,
  input logic                          i_rst,
  serial_magnitude_comparator_if.slave bus
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if (!digits_ok(WIDTH, DIGIT)) begin : g_bad_digit
    $error("WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_g;
  logic             r_e;
  logic             r_l;
  logic             w_gt;
  logic             w_eq;

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .i_a  (r_sha[WIDTH-1 -: DIGIT]),
    .i_b  (r_shb[WIDTH-1 -: DIGIT]),
    .o_gt (w_gt),
    .o_eq (w_eq)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g     <= 1'b0;
      r_e     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.en && bus.start) begin
            // Flipping both sign bits maps two's complement onto offset binary.
            r_sha   <= bus.signed_cmp ? (bus.a ^ MSB_MASK) : bus.a;
            r_shb   <= bus.signed_cmp ? (bus.b ^ MSB_MASK) : bus.b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bus.en) begin
            if (!w_eq) begin
              r_g     <= w_gt;
              r_e     <= 1'b0;
              r_l     <= ~w_gt;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (r_cnt == LAST_DIG) begin
              r_g     <= 1'b0;
              r_e     <= 1'b1;
              r_l     <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_sha <= r_sha << DIGIT;
              r_shb <= r_shb << DIGIT;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.greater = r_g & bus.en;
  assign bus.equal   = r_e & bus.en;
  assign bus.less    = r_l & bus.en;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed and random checks of the serial magnitude comparator
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(16)) bi ();
  serial_magnitude_comparator_if #(.WIDTH(8))  bi8 ();

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bi)
  );

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut8 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bi8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one accepted Start, then counts enabled cycles until Done (bounded).
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         output int lat, output logic busy_acc);
    bi.a          = a;
    bi.b          = b;
    bi.signed_cmp = sg;
    bi.start      = 1'b1;
    tick();
    busy_acc = bi.busy;
    bi.start = 1'b0;
    lat      = 0;
    while (bi.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    x = a ^ b;
    for (int k = 0; k < 4; k++)
      if (x[15 - 4 * k -: 4] != 4'h0) return k + 1;
    return 4;
  endfunction

  function automatic logic [2:0] model_gel(input logic [15:0] a, input logic [15:0] b, input logic sg);
    if (a == b) return 3'b010;
    if (sg) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
    return (a > b) ? 3'b100 : 3'b001;
  endfunction

  initial begin
    int          lat;
    logic        bacc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    rst = 1'b1;
    bi.en = 1'b1; bi.start = 1'b0; bi.signed_cmp = 1'b0; bi.a = '0; bi.b = '0;
    bi8.en = 1'b1; bi8.start = 1'b0; bi8.signed_cmp = 1'b0; bi8.a = '0; bi8.b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(bi.busy), 32'd0);
    check("reset_done", 32'(bi.done), 32'd0);
    check("reset_gel", 32'({bi.greater, bi.equal, bi.less}), 32'd0);

    // 1: equal operands scan every digit
    run_cmp(16'h1234, 16'h1234, 1'b0, lat, bacc);
    check("t1_busy_acc", 32'(bacc), 32'd1);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b010);
    check("t1_busy_done", 32'(bi.busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(bi.done), 32'd0);

    // 2: top digit differs, sign interpretation flips the outcome
    run_cmp(16'h8000, 16'h7FFF, 1'b0, lat, bacc);
    check("t2u_lat", 32'(lat), 32'd1);
    check("t2u_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b100);
    tick();
    run_cmp(16'h8000, 16'h7FFF, 1'b1, lat, bacc);
    check("t2s_lat", 32'(lat), 32'd1);
    check("t2s_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b001);
    tick();

    // 3: third digit differs, then back-to-back Start in the Done cycle
    run_cmp(16'h12F0, 16'h12E0, 1'b0, lat, bacc);
    check("t3a_lat", 32'(lat), 32'd3);
    check("t3a_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b100);
    run_cmp(16'h0001, 16'h0002, 1'b0, lat, bacc);
    check("t3b_busy_acc", 32'(bacc), 32'd1);
    check("t3b_lat", 32'(lat), 32'd4);
    check("t3b_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b001);
    tick();

    // 4: Start while busy is ignored
    bi.a = 16'hFFFF; bi.b = 16'h0000; bi.signed_cmp = 1'b0; bi.start = 1'b1;
    tick();
    bi.a = 16'h0000; bi.b = 16'hFFFF;
    tick();
    bi.start = 1'b0;
    check("t4_done", 32'(bi.done), 32'd1);
    check("t4_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b100);
    tick();
    check("t4_no_restart", 32'(bi.busy), 32'd0);

    // 5: En low mid-scan freezes the scan and masks results
    bi.a = 16'h0003; bi.b = 16'h0005; bi.start = 1'b1;
    tick();
    bi.start = 1'b0;
    tick();
    bi.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_gated_gel", 32'({bi.greater, bi.equal, bi.less}), 32'd0);
      check("t5_no_done", 32'(bi.done), 32'd0);
      check("t5_busy_hold", 32'(bi.busy), 32'd1);
    end
    bi.en = 1'b1;
    lat = 1;
    while (bi.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("t5_lat", 32'(lat), 32'd4);
    check("t5_gel", 32'({bi.greater, bi.equal, bi.less}), 32'b001);

    // 5b: reset aborts a scan and clears results
    bi.a = 16'h1000; bi.b = 16'h1000; bi.start = 1'b1;
    tick();
    bi.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5r_busy", 32'(bi.busy), 32'd0);
    check("t5r_gel", 32'({bi.greater, bi.equal, bi.less}), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5r_no_done", 32'(bi.done), 32'd0);
    end

    // 6: single-digit 8-bit instance, signed
    bi8.a = 8'h7F; bi8.b = 8'h80; bi8.signed_cmp = 1'b1; bi8.start = 1'b1;
    tick();
    bi8.start = 1'b0;
    check("t6_busy", 32'(bi8.busy), 32'd1);
    tick();
    check("t6_done", 32'(bi8.done), 32'd1);
    check("t6_gel", 32'({bi8.greater, bi8.equal, bi8.less}), 32'b100);

    // 6b: random pairs against a reference model
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = (n % 4 == 0) ? ra : 16'($urandom);
      if (n % 5 == 1) rb = {ra[15:4], 4'($urandom)};
      rs = 1'($urandom);
      run_cmp(ra, rb, rs, lat, bacc);
      check("rnd_lat", 32'(lat), 32'(model_lat(ra, rb)));
      check("rnd_gel", 32'({bi.greater, bi.equal, bi.less}), 32'(model_gel(ra, rb, rs)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
